// File: rtl/uart_pkg.sv
// Shared UART receive definitions: default frame width, parity-mode and
// stop-level constants, the decoded FSM strobe type and a parity helper.
package uart_pkg;

    localparam int   DATA_BITS_DEF = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic STOP_LVL = 1'b1;

    // One decoded action per cycle; the FSM strobes collapse onto this.
    typedef enum logic [1:0] {
        STB_NONE   = 2'd0,
        STB_SHIFT  = 2'd1,
        STB_PARITY = 2'd2,
        STB_STOP   = 2'd3
    } strobe_e;

    // 1 when the received parity bit disagrees with the running data parity.
    function automatic logic parity_mismatch(input logic running,
                                             input logic par_bit,
                                             input logic odd_mode);
        return running ^ par_bit ^ odd_mode;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Line conditioning for the UART receiver: two-flop synchroniser for the
// asynchronous serial input plus one history flop for edge detection.
// Every stage resets to the idle-high line level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_serial,
    output logic line_sync,
    output logic line_prev
);

    logic s1_r;

    // Two synchroniser stages followed by the edge-history stage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r      <= 1'b1;
            line_sync <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            s1_r      <= rx_serial;
            line_sync <= s1_r;
            line_prev <= line_sync;
        end
    end

endmodule

// File: rtl/uart_rx_datapath.sv
// UART receive datapath: executes the RX FSM strobes (shift, parity, stop),
// reports the start edge back to the FSM and holds finished frames for a
// valid/ready consumer.
// Build option: UART_RX_HOLD_BUF_EN adds a second holding stage (2-entry
// FIFO); without it a single holding register is used.
module uart_rx_datapath
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_serial,
    input  logic                 shift_bit,
    input  logic                 parity_load,
    input  logic                 check_stop,
    output logic                 start_bit_detect,
    output logic                 parity_bit_err,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam logic ODD_MODE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic                 line_sync_s;
    logic                 line_prev_s;
    logic                 armed_r;
    logic                 run_par_r;
    logic [DATA_BITS-1:0] sr_r;
    logic                 start_cond_s;
    logic                 accept_s;
    logic                 new_ferr_s;
    strobe_e              strobe_s;

    uart_rx_sync u_sync (
        .clk       (clk),
        .rst       (rst),
        .rx_serial (rx_serial),
        .line_sync (line_sync_s),
        .line_prev (line_prev_s)
    );

    assign start_cond_s = armed_r & line_prev_s & ~line_sync_s;
    assign accept_s     = rx_valid & rx_ready;
    assign new_ferr_s   = (line_sync_s != STOP_LVL);

    // Collapse the FSM strobes to one action; nothing acts while waiting for a start edge.
    always_comb begin
        strobe_s = STB_NONE;
        if (armed_r) begin
            strobe_s = STB_NONE;
        end else if (check_stop) begin
            strobe_s = STB_STOP;
        end else if (parity_load) begin
            strobe_s = STB_PARITY;
        end else if (shift_bit) begin
            strobe_s = STB_SHIFT;
        end else begin
            strobe_s = STB_NONE;
        end
    end

    // Start-edge pulse, arming, running parity and the parity error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_bit_detect <= 1'b0;
            armed_r          <= 1'b1;
            run_par_r        <= 1'b0;
            parity_bit_err   <= 1'b0;
        end else begin
            start_bit_detect <= start_cond_s;
            if (start_cond_s) begin
                armed_r        <= 1'b0;
                run_par_r      <= 1'b0;
                parity_bit_err <= 1'b0;
            end else begin
                case (strobe_s)
                    STB_STOP:   armed_r        <= 1'b1;
                    STB_PARITY: parity_bit_err <= parity_mismatch(run_par_r, line_sync_s, ODD_MODE);
                    STB_SHIFT:  run_par_r      <= run_par_r ^ line_sync_s;
                    default:    ;
                endcase
            end
        end
    end

    // LSB-first data shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_r <= '0;
        end else if (strobe_s == STB_SHIFT) begin
            sr_r <= {line_sync_s, sr_r[DATA_BITS-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

`ifdef UART_RX_HOLD_BUF_EN

    logic [DATA_BITS-1:0] tail_data_r;
    logic                 tail_ferr_r;
    logic                 tail_valid_r;
    logic                 push_req_s;
    logic                 push_s;

    assign push_req_s = (strobe_s == STB_STOP);
    assign push_s     = push_req_s & (~tail_valid_r | accept_s);

    // Two-entry FIFO: head drives the consumer outputs, tail catches a second frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data      <= '0;
            frame_err    <= 1'b0;
            rx_valid     <= 1'b0;
            tail_data_r  <= '0;
            tail_ferr_r  <= 1'b0;
            tail_valid_r <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            case ({push_s, accept_s})
                2'b10: begin
                    if (!rx_valid) begin
                        rx_data   <= sr_r;
                        frame_err <= new_ferr_s;
                        rx_valid  <= 1'b1;
                    end else begin
                        tail_data_r  <= sr_r;
                        tail_ferr_r  <= new_ferr_s;
                        tail_valid_r <= 1'b1;
                    end
                end
                2'b01: begin
                    if (tail_valid_r) begin
                        rx_data      <= tail_data_r;
                        frame_err    <= tail_ferr_r;
                        tail_valid_r <= 1'b0;
                    end else begin
                        rx_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    if (tail_valid_r) begin
                        rx_data     <= tail_data_r;
                        frame_err   <= tail_ferr_r;
                        tail_data_r <= sr_r;
                        tail_ferr_r <= new_ferr_s;
                    end else begin
                        rx_data   <= sr_r;
                        frame_err <= new_ferr_s;
                    end
                end
                default: ;
            endcase
            if (push_req_s && !push_s) begin
                overrun <= 1'b1;
            end else begin
                overrun <= overrun;
            end
        end
    end

`else

    // Single holding register; a commit in the accept cycle replaces the old frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data   <= '0;
            frame_err <= 1'b0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else if (strobe_s == STB_STOP) begin
            if (!rx_valid || accept_s) begin
                rx_data   <= sr_r;
                frame_err <= new_ferr_s;
                rx_valid  <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (accept_s) begin
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= rx_valid;
        end
    end

`endif

endmodule

// File: tb/tb_uart_rx_datapath.sv
// Self-checking bench for uart_rx_datapath. The bench plays the RX FSM,
// bit-banging frames at four clocks per bit, and keeps a queue of expected
// {frame_err, data} entries pushed at commit time and popped on output.
module tb_uart_rx_datapath;

`ifdef UART_RX_HOLD_BUF_EN
    localparam int NKEEP = 2;
`else
    localparam int NKEEP = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_serial = 1'b1;
    logic       shift_bit = 1'b0;
    logic       parity_load = 1'b0;
    logic       check_stop = 1'b0;
    logic       rx_ready = 1'b0;
    logic       start_bit_detect;
    logic       parity_bit_err;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int         n_cmp = 0;
    int         n_fail = 0;
    logic [8:0] exp_q[$];
    logic [8:0] e;

    uart_rx_datapath #(.DATA_BITS(8), .PARITY_ODD(0)) dut (
        .clk              (clk),
        .rst              (rst),
        .rx_serial        (rx_serial),
        .shift_bit        (shift_bit),
        .parity_load      (parity_load),
        .check_stop       (check_stop),
        .start_bit_detect (start_bit_detect),
        .parity_bit_err   (parity_bit_err),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .frame_err        (frame_err),
        .overrun          (overrun)
    );

    always #5 clk = ~clk;

    initial begin
        #300us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        rx_serial = 1'b1; shift_bit = 1'b0; parity_load = 1'b0; check_stop = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (4) tick();
        exp_q.delete();
    endtask

    task automatic start_frame;
        int k;
        rx_serial = 1'b1;
        repeat (4) tick();
        rx_serial = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (start_bit_detect !== 1'b1 && k < 12);
        n_cmp++;
        if (start_bit_detect !== 1'b1) begin
            n_fail++;
            $display("FAIL start_wait: start_bit_detect=%b required 1 within 12 cycles", start_bit_detect);
        end
    endtask

    task automatic finish_frame(input logic [7:0] d, input logic p, input logic stop,
                                input logic keep, input logic ready_at_stop);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            repeat (3) tick();
            shift_bit = 1'b1;
            tick();
            shift_bit = 1'b0;
        end
        rx_serial = p;
        repeat (3) tick();
        parity_load = 1'b1;
        tick();
        parity_load = 1'b0;
        rx_serial = stop;
        repeat (3) tick();
        check_stop = 1'b1;
        if (ready_at_stop) rx_ready = 1'b1;
        if (keep) exp_q.push_back({~stop, d});
        tick();
        check_stop = 1'b0;
        rx_serial = 1'b1;
    endtask

    task automatic test_reset;
        int pulses;
        rst = 1'b0;
        tick();
        n_cmp++;
        if ({start_bit_detect, parity_bit_err, rx_valid, frame_err, overrun} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {start_bit_detect, parity_bit_err, rx_valid, frame_err, overrun});
        end
        n_cmp++;
        if (rx_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_data: rx_data=%h required 00", rx_data);
        end
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (start_bit_detect === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL idle_no_start: pulses=%0d required 0", pulses);
        end
    endtask

    task automatic test_start;
        logic [4:0] seen;
        int pulses;
        rx_ready = 1'b1;
        rx_serial = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            seen[i] = start_bit_detect;
        end
        n_cmp++;
        if (seen !== 5'b00100) begin
            n_fail++;
            $display("FAIL start_timing: pulse pattern=%b required 00100", seen);
        end
        rx_serial = 1'b1;
        repeat (4) tick();
        rx_serial = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (start_bit_detect === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL start_disarmed: pulses=%0d required 0", pulses);
        end
        rx_serial = 1'b1;
        repeat (3) tick();
        check_stop = 1'b1;
        exp_q.push_back(9'h000);
        tick();
        check_stop = 1'b0;
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || {frame_err, rx_data} !== e) begin
            n_fail++;
            $display("FAIL empty_commit: valid=%b ferr/data=%h required 1 / %h", rx_valid, {frame_err, rx_data}, e);
        end
        tick();
    endtask

    task automatic test_good_frame;
        rx_ready = 1'b1;
        start_frame();
        finish_frame(8'hA5, ^(8'hA5), 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e[7:0] || frame_err !== e[8]) begin
            n_fail++;
            $display("FAIL good_frame: valid=%b data=%h ferr=%b required 1 %h %b", rx_valid, rx_data, frame_err, e[7:0], e[8]);
        end
        n_cmp++;
        if (parity_bit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL good_parity: parity_bit_err=%b required 0", parity_bit_err);
        end
        tick();
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL good_valid_drop: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_parity_err;
        rx_ready = 1'b1;
        start_frame();
        finish_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (parity_bit_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_err_set: parity_bit_err=%b required 1", parity_bit_err);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL parity_frame_data: valid=%b data=%h required 1 %h", rx_valid, rx_data, e[7:0]);
        end
        tick();
        start_frame();
        n_cmp++;
        if (parity_bit_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_err_clear: parity_bit_err=%b required 0", parity_bit_err);
        end
        finish_frame(8'h02, ^(8'h02), 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (parity_bit_err !== 1'b0 || rx_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL parity_ok_frame: perr=%b data=%h required 0 %h", parity_bit_err, rx_data, e[7:0]);
        end
        tick();
    endtask

    task automatic test_frame_err;
        rx_ready = 1'b1;
        start_frame();
        finish_frame(8'h3C, ^(8'h3C), 1'b0, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || frame_err !== e[8] || rx_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL frame_err_set: valid=%b ferr=%b data=%h required 1 %b %h", rx_valid, frame_err, rx_data, e[8], e[7:0]);
        end
        tick();
        start_frame();
        finish_frame(8'h5A, ^(8'h5A), 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || frame_err !== e[8] || rx_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL frame_err_clear: valid=%b ferr=%b data=%h required 1 %b %h", rx_valid, frame_err, rx_data, e[8], e[7:0]);
        end
        tick();
    endtask

    task automatic test_same_cycle;
        rx_ready = 1'b0;
        start_frame();
        finish_frame(8'h44, ^(8'h44), 1'b1, 1'b1, 1'b0);
        tick();
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e[7:0]) begin
            n_fail++;
            $display("FAIL hold_first: valid=%b data=%h required 1 %h", rx_valid, rx_data, e[7:0]);
        end
        start_frame();
        finish_frame(8'h55, ^(8'h55), 1'b1, 1'b1, 1'b1);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e[7:0] || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_commit: valid=%b data=%h ovr=%b required 1 %h 0", rx_valid, rx_data, overrun, e[7:0]);
        end
        tick();
        n_cmp++;
        if (rx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_commit_drain: rx_valid=%b required 0", rx_valid);
        end
    endtask

    task automatic test_overrun;
        logic [7:0] b;
        do_reset();
        rx_ready = 1'b0;
        for (int k = 0; k <= NKEEP; k++) begin
            b = 8'(8'h11 * (k + 1));
            start_frame();
            finish_frame(b, ^b, 1'b1, (k < NKEEP), 1'b0);
            if (k < NKEEP) begin
                n_cmp++;
                if (overrun !== 1'b0) begin
                    n_fail++;
                    $display("FAIL overrun_early: frame %0d overrun=%b required 0", k, overrun);
                end
            end
        end
        n_cmp++;
        if (overrun !== 1'b1 || rx_valid !== 1'b1 || rx_data !== exp_q[0][7:0]) begin
            n_fail++;
            $display("FAIL overrun_set: ovr=%b valid=%b data=%h required 1 1 %h", overrun, rx_valid, rx_data, exp_q[0][7:0]);
        end
        rx_ready = 1'b1;
        for (int k = 0; k < NKEEP; k++) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (rx_valid !== 1'b1 || rx_data !== e[7:0]) begin
                n_fail++;
                $display("FAIL overrun_drain%0d: valid=%b data=%h required 1 %h", k, rx_valid, rx_data, e[7:0]);
            end
            tick();
        end
        n_cmp++;
        if (rx_valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: valid=%b ovr=%b required 0 1", rx_valid, overrun);
        end
    endtask

    task automatic test_mid_reset;
        rx_ready = 1'b1;
        start_frame();
        rx_serial = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            shift_bit = 1'b1;
            tick();
            shift_bit = 1'b0;
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({start_bit_detect, parity_bit_err, rx_valid, frame_err, overrun} !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b required 00000",
                     {start_bit_detect, parity_bit_err, rx_valid, frame_err, overrun});
        end
        tick();
        rst = 1'b1;
        repeat (2) tick();
        exp_q.delete();
        start_frame();
        finish_frame(8'hC3, ^(8'hC3), 1'b1, 1'b1, 1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if (rx_valid !== 1'b1 || rx_data !== e[7:0] || frame_err !== e[8]) begin
            n_fail++;
            $display("FAIL after_mid_reset: valid=%b data=%h ferr=%b required 1 %h %b", rx_valid, rx_data, frame_err, e[7:0], e[8]);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_start();
        test_good_frame();
        test_parity_err();
        test_frame_err();
        test_same_cycle();
        test_overrun();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
